shift_right_seq: RTL and testbench

Multi-cycle 32-bit right shifter for the CPU datapath. It performs the SRL and SRA operations that the fixed left-shift units do not cover. It accepts an operand and a shift amount through a start/done handshake, shifts one bit position per clock, and presents the registered result to the ALU result mux. The main control stalls the pipeline while `busy_o` is high.

---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_right_one.sv | 31 +++
 rtl/shift_right_seq.sv | 170 +++++++++++++++++
 tb/tb_shift_right_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
//
// Shared definitions for the multi-cycle right shifter used by the CPU
// datapath (SRL / SRA). Holds the controller state type, the datapath width
// constants and a small helper that tells whether a state may accept a new
// request.
//
// Contents:
//   shift_state_t     - controller states IDLE, SHIFT, DONE
//   SHIFT_DATA_W      - operand width (32)
//   SHIFT_SHAMT_W     - shift-amount width (5 = log2 of SHIFT_DATA_W)
//   shift_can_accept  - 1 when a state samples start_i
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam int SHIFT_DATA_W  = 32;
  localparam int SHIFT_SHAMT_W = 5;

  // IDLE waits for a request, SHIFT walks one bit per clock, DONE is the
  // single cycle in which done_o is presented.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  // A request is only looked at when no operation is in flight. DONE counts
  // as "not in flight" so the pipeline can issue back-to-back shifts.
  function automatic logic shift_can_accept(input shift_state_t state);
    return (state == IDLE) || (state == DONE);
  endfunction

endpackage : shift_pkg

// File: rtl/shift_right_one.sv
// ---------------------------------------------------------------------------
// shift_right_one
//
// Combinational single-step right shifter. Moves the word one position to the
// right and inserts the supplied fill bit at the top. The sequential shifter
// applies this once per clock to its work register.
//
// Parameters:
//   DATA_W        - word width (default SHIFT_DATA_W)
//
// Ports:
//   word          in   DATA_W  value to shift
//   fill          in   1       bit inserted at the MSB
//   word_shifted  out  DATA_W  {fill, word[DATA_W-1:1]}
// ---------------------------------------------------------------------------
module shift_right_one
  import shift_pkg::*;
#(
  parameter int DATA_W = SHIFT_DATA_W
) (
  input  logic [DATA_W-1:0] word,
  input  logic              fill,
  output logic [DATA_W-1:0] word_shifted
);

  // The LSB falls off the end; the fill bit takes the vacated MSB. For an
  // arithmetic shift the caller keeps fill equal to the original sign bit,
  // which makes repeated single steps equivalent to one wide SRA.
  assign word_shifted = {fill, word[DATA_W-1:1]};

endmodule : shift_right_one

// File: rtl/shift_right_seq.sv
// ---------------------------------------------------------------------------
// shift_right_seq
//
// Multi-cycle right shifter for the CPU datapath, covering SRL and SRA. A
// request is accepted through start_i, the operand is shifted one bit per
// clock, and the final value is registered onto data_o together with a
// one-cycle done_o pulse. busy_o is high while shifting so the main control
// can stall the pipeline.
//
// Configuration macro:
//   SHIFT_RIGHT_ARITH_EN  defined   -> arith_i selects sign fill (SRA)
//                         undefined -> arith_i is ignored, always zero fill
//
// Parameters:
//   DATA_W   - operand width, only 32 is supported
//   SHAMT_W  - shift-amount width, must equal log2(DATA_W)
//
// Ports:
//   clk_i    in   1        clock, rising edge
//   rst_i    in   1        synchronous active-high reset
//   start_i  in   1        request, sampled only in IDLE or DONE
//   data_i   in   DATA_W   operand, captured on accept
//   shamt_i  in   SHAMT_W  shift amount 0..31, captured on accept
//   arith_i  in   1        1 = sign fill, 0 = zero fill, captured on accept
//   busy_o   out  1        high while shifting
//   done_o   out  1        one-cycle pulse, data_o valid
//   data_o   out  DATA_W   last completed result, held until next completion
// ---------------------------------------------------------------------------
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int DATA_W  = SHIFT_DATA_W,
  parameter int SHAMT_W = SHIFT_SHAMT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               arith_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  data_o
);

  shift_state_t       state_q;
  shift_state_t       state_d;

  logic [DATA_W-1:0]  work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               fill_q;
  logic [DATA_W-1:0]  result_q;

  logic               accept;
  logic               zero_shamt;
  logic               last_step;
  logic               fill_in;
  logic [DATA_W-1:0]  work_shifted;

  // A request is taken only when idle or finishing; start_i during SHIFT is
  // dropped on the floor rather than queued.
  assign accept     = start_i && shift_can_accept(state_q);
  assign zero_shamt = (shamt_i == '0);

  // The counter still holds 1 on the edge that performs the final step, so
  // that edge both writes the result and moves to DONE.
  assign last_step  = (cnt_q == SHAMT_W'(1));

  // Fill bit for the new request. It is captured once and reused on every
  // step, so the original sign bit is replicated even though bit 31 of the
  // work register changes as the operation progresses.
`ifdef SHIFT_RIGHT_ARITH_EN
  assign fill_in = arith_i & data_i[DATA_W-1];
`else
  logic arith_unused;
  assign arith_unused = arith_i;
  assign fill_in      = 1'b0;
`endif

  // One step of the shift, applied to the work register each SHIFT cycle.
  shift_right_one #(
    .DATA_W (DATA_W)
  ) u_step (
    .word         (work_q),
    .fill         (fill_q),
    .word_shifted (work_shifted)
  );

  // State register. Reset wins over any transition, so a reset in the middle
  // of a shift simply abandons it and no done_o is ever produced for it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero shift amount skips SHIFT entirely and lands in
  // DONE on the accepting edge, giving the minimum one-cycle latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = zero_shamt ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_d = zero_shamt ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers. On accept the operand, count and fill bit are frozen
  // so later input changes cannot disturb the operation. The result register
  // is written only on the completing edge, which keeps intermediate shift
  // values off data_o; for a zero shift that edge is the accepting edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      work_q   <= '0;
      cnt_q    <= '0;
      fill_q   <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      work_q <= data_i;
      cnt_q  <= shamt_i;
      fill_q <= fill_in;
      if (zero_shamt) begin
        result_q <= data_i;
      end
    end else if (state_q == SHIFT) begin
      work_q <= work_shifted;
      cnt_q  <= cnt_q - SHAMT_W'(1);
      if (last_step) begin
        result_q <= work_shifted;
      end
    end
  end

  // Output decode. Both flags come straight from the state register, so
  // there is no combinational path from any input to the outputs.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      SHIFT:   busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  assign data_o = result_q;

endmodule : shift_right_seq

// File: tb/tb_shift_right_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_right_seq
//
// Self-checking bench for shift_right_seq. Expected results come from a plain
// arithmetic shift model; expected timing is derived from the shift amount.
// Honours SHIFT_RIGHT_ARITH_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_shift_right_seq;

`ifdef SHIFT_RIGHT_ARITH_EN
  localparam bit ARITH_EN = 1'b1;
`else
  localparam bit ARITH_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;
  logic        arith_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_result;

  shift_right_seq dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .data_i  (data_i),
    .shamt_i (shamt_i),
    .arith_i (arith_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o)
  );

  // 100 MHz clock
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference result: a whole-word logical or arithmetic shift.
  function automatic logic [31:0] refShift(input logic [31:0] d, input logic [4:0] sh,
                                           input logic ar);
    logic signed [31:0] sd;
    sd = $signed(d);
    if (ar && ARITH_EN) return $unsigned(sd >>> sh);
    return d >> sh;
  endfunction

  // Issues a request at the current falling edge, then follows it cycle by
  // cycle: busy for sh cycles with data_o held, then one done cycle with the
  // new result. While busy the inputs are scrambled (start included) to show
  // they are frozen and that start is ignored. Returns on the falling edge
  // after the done edge with start_i low, so an immediate further call is a
  // back-to-back request sampled in DONE.
  task automatic applyStimulus(input logic [31:0] d, input logic [4:0] sh,
                               input logic ar, input bit intrude);
    logic [31:0] exp_val;
    exp_val = refShift(d, sh, ar);
    start_i = 1'b1;
    data_i  = d;
    shamt_i = sh;
    arith_i = ar;
    @(negedge clk_i);
    for (int j = 0; j < int'(sh); j++) begin
      checkOutput("busy_during_shift", 32'(busy_o), 32'd1);
      checkOutput("done_during_shift", 32'(done_o), 32'd0);
      checkOutput("data_held_during_shift", data_o, last_result);
      if (intrude && j == 2) begin
        start_i = 1'b1;
        data_i  = 32'h0000FFFF;
        shamt_i = 5'd4;
        arith_i = 1'b0;
      end else begin
        start_i = 1'($urandom_range(0, 1));
        data_i  = $urandom;
        shamt_i = 5'($urandom);
        arith_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk_i);
    end
    checkOutput("done_pulse", 32'(done_o), 32'd1);
    checkOutput("busy_at_done", 32'(busy_o), 32'd0);
    checkOutput("result", data_o, exp_val);
    last_result = exp_val;
    start_i = 1'b0;
    data_i  = $urandom;
    shamt_i = 5'($urandom);
    arith_i = 1'($urandom_range(0, 1));
  endtask

  // One cycle with no request: done must have dropped and data_o held.
  task automatic idleCycle();
    start_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idle_done", 32'(done_o), 32'd0);
    checkOutput("idle_busy", 32'(busy_o), 32'd0);
    checkOutput("idle_data", data_o, last_result);
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    data_i  = '0;
    shamt_i = '0;
    arith_i = 1'b0;
    last_result = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_data", data_o, 32'd0);
    rst_i = 1'b0;
    idleCycle();

    // Logical shift by 3
    applyStimulus(32'h80000000, 5'd3, 1'b0, 1'b0);
    idleCycle();
    checkOutput("plan_logical", data_o, 32'h10000000);

    // Arithmetic shift by 3
    applyStimulus(32'h80000000, 5'd3, 1'b1, 1'b0);
    idleCycle();
    checkOutput("plan_arith", data_o, ARITH_EN ? 32'hF0000000 : 32'h10000000);

    // Zero shift
    applyStimulus(32'h12345678, 5'd0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("plan_zero", data_o, 32'h12345678);

    // Maximum shift, logical then arithmetic back-to-back
    applyStimulus(32'hFFFFFFFF, 5'd31, 1'b0, 1'b0);
    checkOutput("plan_max_logical", data_o, 32'h00000001);
    applyStimulus(32'hFFFFFFFF, 5'd31, 1'b1, 1'b0);
    idleCycle();
    checkOutput("plan_max_arith", data_o, ARITH_EN ? 32'hFFFFFFFF : 32'h00000001);

    // Start during an active shamt=8 run is ignored, then a back-to-back
    // start in the DONE cycle is accepted.
    applyStimulus(32'hA5A50F0F, 5'd8, 1'b1, 1'b1);
    applyStimulus(32'h0F0F0000, 5'd2, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("plan_back_to_back", data_o, 32'h03C3C000);

    // Reset in cycle 5 of a shamt=10 run aborts it with no done pulse
    start_i = 1'b1;
    data_i  = 32'hDEADBEEF;
    shamt_i = 5'd10;
    arith_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("midreset_busy", 32'(busy_o), 32'd0);
    checkOutput("midreset_done", 32'(done_o), 32'd0);
    checkOutput("midreset_data", data_o, 32'd0);
    last_result = '0;
    repeat (12) idleCycle();
    applyStimulus(32'h13579BDF, 5'd1, 1'b0, 1'b0);
    idleCycle();

    // Randomized requests, with and without idle gaps
    repeat (60) begin
      applyStimulus($urandom, 5'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) idleCycle();
    end
    idleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shift_right_seq
